// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Wide add/subtract built from one shared 8-bit carry-select slice that is
// stepped across the operand LSB slice first. The carry between slices is
// kept in a register. The full-width result is returned through a
// valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; oReady high
//   RUN   | one slice per cycle, slice index 0 .. NUM_SLICES-1
//   DONE  | result held on oSum/oCarry/oOverflow until iReady
module multiword_add_sequencer #(
  parameter int SLICE_WIDTH = 8,
  parameter int NUM_SLICES  = 4
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iValid,
  output logic                                oReady,
  input  logic [SLICE_WIDTH*NUM_SLICES-1:0]   iA,
  input  logic [SLICE_WIDTH*NUM_SLICES-1:0]   iB,
  input  logic                                iSub,
  input  logic                                iCarry,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [SLICE_WIDTH*NUM_SLICES-1:0]   oSum,
  output logic                                oCarry,
  output logic                                oOverflow,
  output logic                                oBusy
);

  localparam int OPERAND_WIDTH = SLICE_WIDTH * NUM_SLICES;
  localparam int IDX_W         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int SLICE_LOG2    = $clog2(SLICE_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // The slice datapath is hard-wired for 8-bit slices.
  generate
    if (SLICE_WIDTH != 8) begin : gBadSliceWidth
      $error("multiword_add_sequencer: SLICE_WIDTH must be 8");
    end
    if (NUM_SLICES < 1) begin : gBadNumSlices
      $error("multiword_add_sequencer: NUM_SLICES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                     state;
  logic [IDX_W-1:0]          idx;
  logic                      carryReg;
  logic [OPERAND_WIDTH-1:0]  aReg;
  logic [OPERAND_WIDTH-1:0]  bxReg;
  logic [OPERAND_WIDTH-1:0]  sumReg;

  logic [IDX_W+SLICE_LOG2-1:0] sliceBase;
  logic [SLICE_WIDTH-1:0]      aSlice;
  logic [SLICE_WIDTH-1:0]      bSlice;
  logic [SLICE_WIDTH:0]        sumNoCarry;
  logic [SLICE_WIDTH:0]        sumWithCarry;
  logic [SLICE_WIDTH:0]        sliceResult;

  assign sliceBase = {idx, {SLICE_LOG2{1'b0}}};
  assign aSlice    = aReg[sliceBase +: SLICE_WIDTH];
  assign bSlice    = bxReg[sliceBase +: SLICE_WIDTH];

  // Carry-select slice: both carry-in cases are formed in parallel and the
  // registered carry picks one, keeping the carry register off the adder chain.
  always_comb begin
    sumNoCarry   = {1'b0, aSlice} + {1'b0, bSlice};
    sumWithCarry = sumNoCarry + {{SLICE_WIDTH{1'b0}}, 1'b1};
    sliceResult  = carryReg ? sumWithCarry : sumNoCarry;
  end

  // Sequencer: capture operands, step the slice index, register the result.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      idx       <= '0;
      carryReg  <= 1'b0;
      aReg      <= '0;
      bxReg     <= '0;
      sumReg    <= '0;
      oCarry    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            // Subtraction is A + ~B + 1; a borrow-in removes the +1.
            aReg     <= iA;
            bxReg    <= iB ^ {OPERAND_WIDTH{iSub}};
            carryReg <= iCarry ^ iSub;
            idx      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          sumReg[sliceBase +: SLICE_WIDTH] <= sliceResult[SLICE_WIDTH-1:0];
          carryReg <= sliceResult[SLICE_WIDTH];
          if (idx == LAST_IDX) begin
            oCarry    <= sliceResult[SLICE_WIDTH];
            oOverflow <= (aReg[OPERAND_WIDTH-1] == bxReg[OPERAND_WIDTH-1]) &&
                         (sliceResult[SLICE_WIDTH-1] != aReg[OPERAND_WIDTH-1]);
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (iReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oSum   = sumReg;
  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);
  assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed corner cases followed by
// randomized operations checked against an arithmetic reference model.
module tb_multiword_add_sequencer;

  localparam int NS = 4;
  localparam int OW = 8 * NS;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iValid;
  logic          oReady;
  logic [OW-1:0] iA;
  logic [OW-1:0] iB;
  logic          iSub;
  logic          iCarry;
  logic          oValid;
  logic          iReady;
  logic [OW-1:0] oSum;
  logic          oCarry;
  logic          oOverflow;
  logic          oBusy;

  int tests = 0;
  int fails = 0;

  multiword_add_sequencer #(.SLICE_WIDTH(8), .NUM_SLICES(NS)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iValid   (iValid),
    .oReady   (oReady),
    .iA       (iA),
    .iB       (iB),
    .iSub     (iSub),
    .iCarry   (iCarry),
    .oValid   (oValid),
    .iReady   (iReady),
    .oSum     (oSum),
    .oCarry   (oCarry),
    .oOverflow(oOverflow),
    .oBusy    (oBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width values.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin,
                                   output logic [31:0] s, output logic c,
                                   output logic ov);
    longint ua, ub, sa, sb, ci, u, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = cin ? 64'sd1 : 64'sd0;
    if (!sub) begin
      u = ua + ub + ci;
      c = (u >= 64'sd4294967296);
      r = sa + sb + ci;
    end else begin
      u = ua - ub - ci;
      c = (u >= 0);
      r = sa - sb - ci;
    end
    s  = u[31:0];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // One full transaction: request, latency, optional stall, handoff.
  task automatic doOp(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic cin,
                      input int stall, input string tag);
    logic [31:0] es;
    logic        ec, eo;
    int          n;
    refModel(a, b, sub, cin, es, ec, eo);
    iReady = 1'b0;
    iA = a; iB = b; iSub = sub; iCarry = cin; iValid = 1'b1;
    check({tag, ".ready"}, oReady, 1);
    tick;
    // Inputs are only sampled at the accepting edge; disturb them afterwards.
    iA = $urandom; iB = $urandom; iSub = 1'($urandom); iCarry = 1'($urandom);
    n = 0;
    while (oValid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, ".latency"}, n, NS);
    check({tag, ".sum"}, oSum, es);
    check({tag, ".carry"}, oCarry, ec);
    check({tag, ".ovf"}, oOverflow, eo);
    for (int i = 0; i < stall; i++) begin
      tick;
      check({tag, ".stallValid"}, oValid, 1);
      check({tag, ".stallReady"}, oReady, 0);
      check({tag, ".stallHold"}, {oOverflow, oCarry, oSum}, {eo, ec, es});
    end
    iReady = 1'b1;
    tick;
    iReady = 1'b0;
    iValid = 1'b0;
    check({tag, ".handoff"}, {oValid, oReady, oBusy}, 3'b010);
    check({tag, ".keep"}, {oOverflow, oCarry, oSum}, {eo, ec, es});
  endtask

  logic [31:0] corners [4];
  logic [31:0] ra, rb;

  initial begin
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0;
    iA = '0; iB = '0; iSub = 1'b0; iCarry = 1'b0;
    tick;
    tick;
    iRst = 1'b0;
    check("reset.flags", {oReady, oValid, oBusy}, 3'b100);
    check("reset.outs", {oOverflow, oCarry, oSum}, 34'h0);

    doOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "ripple");
    check("ripple.expl", {oOverflow, oCarry, oSum}, {1'b0, 1'b1, 32'h0000_0000});
    doOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "sovf");
    check("sovf.expl", {oOverflow, oCarry, oSum}, {1'b1, 1'b0, 32'h8000_0000});
    doOp(32'd5, 32'd3, 1'b1, 1'b0, 0, "sub53");
    check("sub53.expl", {oCarry, oSum}, {1'b1, 32'h0000_0002});
    doOp(32'd3, 32'd5, 1'b1, 1'b0, 0, "sub35");
    check("sub35.expl", {oCarry, oSum}, {1'b0, 32'hFFFF_FFFE});
    doOp(32'd5, 32'd3, 1'b1, 1'b1, 0, "sub53b");
    check("sub53b.expl", oSum, 32'h0000_0001);
    doOp(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b1, 3, "bp");

    // Reset while the slice index is at 2.
    iA = 32'hDEAD_BEEF; iB = 32'h1234_5678; iSub = 1'b0; iCarry = 1'b1; iValid = 1'b1;
    tick;
    iValid = 1'b0;
    tick;
    tick;
    iRst = 1'b1;
    tick;
    iRst = 1'b0;
    check("midrst.flags", {oReady, oValid, oBusy}, 3'b100);
    check("midrst.sum", oSum, 32'h0);
    tick;
    check("midrst.idle", {oReady, oValid}, 2'b10);
    doOp(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "postrst");
    check("postrst.expl", oSum, 32'h2345_6789);

    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      doOp(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
